// File: rtl/common.sv
// Shared pipeline types: instruction layout, register-file geometry and the
// opcode classification used by decode, operand fetch and writeback.
package common;

   localparam int REGISTER_WIDTH = 32;
   localparam int NUM_REGS       = 32;

   typedef logic [4:0]                reg_index_t;
   typedef logic [REGISTER_WIDTH-1:0] reg_data_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      R_TYPE = 2'd1,
      I_TYPE = 2'd2,
      OP_SYS = 2'd3
   } opcode_t;

   typedef struct packed {
      logic [6:0] funct7;
      reg_index_t rs2;
      reg_index_t rs1;
      logic [2:0] funct3;
      reg_index_t rd;
   } r_type_t;

   typedef struct packed {
      logic [11:0] imm;
      reg_index_t  rs1;
      logic [2:0]  funct3;
      reg_index_t  rd;
   } i_type_t;

   typedef union packed {
      r_type_t r_type;
      i_type_t i_type;
   } instr_fields_t;

   typedef struct packed {
      opcode_t       opcode;
      instr_fields_t fields;
   } instruction_t;

   function automatic logic writes_rd(instruction_t instr);
      return (instr.opcode == R_TYPE) || (instr.opcode == I_TYPE);
   endfunction

   function automatic logic uses_rs1(instruction_t instr);
      return (instr.opcode == R_TYPE) || (instr.opcode == I_TYPE);
   endfunction

   function automatic logic uses_rs2(instruction_t instr);
      return instr.opcode == R_TYPE;
   endfunction

   // rs1 and rd sit at the same bit positions in both formats; pick the view
   // that matches the opcode so the intent stays readable.
   function automatic reg_index_t rs1_of(instruction_t instr);
      return (instr.opcode == I_TYPE) ? instr.fields.i_type.rs1 : instr.fields.r_type.rs1;
   endfunction

   function automatic reg_index_t rs2_of(instruction_t instr);
      return instr.fields.r_type.rs2;
   endfunction

   function automatic reg_index_t rd_of(instruction_t instr);
      return (instr.opcode == I_TYPE) ? instr.fields.i_type.rd : instr.fields.r_type.rd;
   endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 reads as zero and ignores writes.
module register_file
   import common::*;
#(
   parameter int        DEPTH       = 32,
   parameter reg_data_t RESET_VALUE = '0
) (
   input  logic       clk,
   input  logic       reset,
   input  reg_index_t rd_addr_a,
   output reg_data_t  rd_data_a,
   input  reg_index_t rd_addr_b,
   output reg_data_t  rd_data_b,
   input  logic       wr_en,
   input  reg_index_t wr_addr,
   input  reg_data_t  wr_data
);

   reg_data_t mem [DEPTH];

   // Storage update: reset fills every entry, otherwise a non-x0 write lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads sources with writeback bypass, tracks in-flight
// destinations in a pending scoreboard to stall RAW hazards, and presents a
// one-deep registered output to the execution unit.
module operand_fetch_stage
   import common::*;
#(
   parameter int        NUM_REGS    = common::NUM_REGS,
   parameter reg_data_t RESET_VALUE = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  instruction_t in_instruction,
   output logic         out_valid,
   input  logic         out_ready,
   output instruction_t decoded_instruction,
   output reg_data_t    rs1_value,
   output reg_data_t    rs2_value,
   input  logic         wb_valid,
   input  reg_index_t   wb_rd,
   input  reg_data_t    wb_data,
   input  logic         flush
);

   reg_index_t          src1_idx;
   reg_index_t          src2_idx;
   reg_index_t          dst_idx;
   logic                src1_used;
   logic                src2_used;
   logic                src1_bypass;
   logic                src2_bypass;
   logic                hazard;
   logic                accept;
   reg_data_t           rf_data1;
   reg_data_t           rf_data2;
   reg_data_t           src1_value;
   reg_data_t           src2_value;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_next;

   assign src1_idx  = rs1_of(in_instruction);
   assign src2_idx  = rs2_of(in_instruction);
   assign dst_idx   = rd_of(in_instruction);
   assign src1_used = uses_rs1(in_instruction);
   assign src2_used = uses_rs2(in_instruction);

   register_file #(
      .DEPTH       (NUM_REGS),
      .RESET_VALUE (RESET_VALUE)
   ) u_register_file (
      .clk       (clk),
      .reset     (reset),
      .rd_addr_a (src1_idx),
      .rd_data_a (rf_data1),
      .rd_addr_b (src2_idx),
      .rd_data_b (rf_data2),
      .wr_en     (wb_valid),
      .wr_addr   (wb_rd),
      .wr_data   (wb_data)
   );

   assign src1_bypass = wb_valid && (wb_rd == src1_idx) && (src1_idx != '0);
   assign src2_bypass = wb_valid && (wb_rd == src2_idx) && (src2_idx != '0);

   assign src1_value = !src1_used ? '0 : (src1_bypass ? wb_data : rf_data1);
   assign src2_value = !src2_used ? '0 : (src2_bypass ? wb_data : rf_data2);

   // A source that is bypassed this cycle is already resolved, so it never stalls.
   assign hazard = (src1_used && (src1_idx != '0) && pending[src1_idx] && !src1_bypass) ||
                   (src2_used && (src2_idx != '0) && pending[src2_idx] && !src2_bypass);

   assign in_ready = !reset && !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Scoreboard next state: clears first, then the accept set so the younger
   // instruction wins on a same-index collision.
   always_comb begin
      pending_next = pending;
      if (wb_valid) begin
         pending_next[wb_rd] = 1'b0;
      end
      if (flush && out_valid && writes_rd(decoded_instruction)) begin
         pending_next[rd_of(decoded_instruction)] = 1'b0;
      end
      if (accept && writes_rd(in_instruction) && (dst_idx != '0)) begin
         pending_next[dst_idx] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Output pipeline register: load on accept, drain on consume or flush, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid           <= 1'b0;
         decoded_instruction <= '0;
         rs1_value           <= '0;
         rs2_value           <= '0;
      end else if (accept) begin
         out_valid           <= 1'b1;
         decoded_instruction <= in_instruction;
         rs1_value           <= src1_value;
         rs2_value           <= src2_value;
      end else if (flush || out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
